// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and defaults for the UART transmit arbiter
//
// Purpose : FSM state encoding, default parameter values and the grant-id
//           width helper shared by uart_tx_arbiter and its sub-modules.
// Ports   : none (package).
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  localparam int N_REQ_DEF          = 4;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

  // Width of a requester index; never narrower than one bit.
  function automatic int gid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin priority picker
//
// Purpose : picks the first set bit of i_valid searching upward from i_ptr
//           with wrap-around. Self-contained so other shared-peripheral
//           arbiters can reuse it.
// Ports   : i_valid  [N]  request vector
//           i_ptr    [W]  highest-priority index this cycle (must be < N)
//           o_onehot [N]  one-hot of the chosen requester (0 if none)
//           o_idx    [W]  index of the chosen requester (0 if none)
//           o_any         at least one request is set
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_valid,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_onehot,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  logic [W:0]   sum;
  logic [W-1:0] pos;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    sum      = '0;
    pos      = '0;
    for (int i = 0; i < N; i++) begin
      // Candidate i positions after the pointer, wrapped into 0..N-1.
      sum = {1'b0, i_ptr} + (W+1)'(i);
      if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
      pos = sum[W-1:0];
      if (!o_any && i_valid[pos]) begin
        o_onehot[pos] = 1'b1;
        o_idx         = pos;
        o_any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter
//
// Purpose : grants one of N_REQ byte requesters, latches its byte and runs
//           the UART start/busy handshake, then releases start for one cycle
//           so the UART returns to idle before the next grant.
// Macro   : UART_ARB_TIMEOUT_EN - when defined, START gives up after
//           TIMEOUT_CYCLES cycles without busy and sets the sticky o_err.
// Ports   : i_clk, i_rst (synchronous, active-low)
//           i_req_valid [N_REQ]    per-requester byte available (level)
//           i_req_data  [8*N_REQ]  requester k byte at [8k+7:8k]
//           o_req_ready [N_REQ]    one-hot pulse: byte of requester k latched
//           o_str_tx, o_data_tx[8] UART start and data inputs
//           i_busy_tx              UART busy output
//           o_grant_id             index of current/last granted requester
//           o_active               high from grant until RELEASE completes
//           o_done                 pulse when a byte transfer completes
//           o_err                  sticky start timeout
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ          = N_REQ_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [8*N_REQ-1:0]         i_req_data,
  output logic [N_REQ-1:0]           o_req_ready,
  output logic                       o_str_tx,
  output logic [7:0]                 o_data_tx,
  input  logic                       i_busy_tx,
  output logic [gid_w(N_REQ)-1:0]    o_grant_id,
  output logic                       o_active,
  output logic                       o_done,
  output logic                       o_err
);

  localparam int GW = gid_w(N_REQ);

  arb_state_t      state, next_state;
  logic [GW-1:0]   rr_ptr;
  logic [N_REQ-1:0] pick_oh;
  logic [GW-1:0]   pick_idx;
  logic            pick_any;
  logic [7:0]      pick_byte;
  logic            grant;
  logic            timeout;

  rr_pick #(.N(N_REQ), .W(GW)) u_pick (
    .i_valid  (i_req_valid),
    .i_ptr    (rr_ptr),
    .o_onehot (pick_oh),
    .o_idx    (pick_idx),
    .o_any    (pick_any)
  );

  always_comb begin
    pick_byte = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_oh[k]) pick_byte = i_req_data[8*k +: 8];
    end
  end

  assign grant = (state == ST_IDLE) && pick_any;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] to_cnt;
  logic          err_q;

  // Counter is 0 on the first START cycle, so START lasts TIMEOUT_CYCLES.
  assign timeout = (state == ST_START) && !i_busy_tx &&
                   (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst)                 to_cnt <= '0;
    else if (state != ST_START) to_cnt <= '0;
    else                        to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst)       err_q <= 1'b0;
    else if (timeout) err_q <= 1'b1;
  end

  assign o_err = err_q;
`else
  // TIMEOUT_CYCLES stays on the interface so both builds share one
  // instantiation; without the counter START waits indefinitely.
  assign timeout = 1'b0 && (TIMEOUT_CYCLES < 0);
  assign o_err   = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (pick_any) next_state = ST_START;
      ST_START: begin
        if (i_busy_tx)    next_state = ST_BUSY;
        else if (timeout) next_state = ST_RELEASE;
      end
      ST_BUSY:    if (!i_busy_tx) next_state = ST_RELEASE;
      ST_RELEASE: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only, so busy never reaches
  // an output combinationally.
  always_comb begin
    o_str_tx = (state == ST_START) || (state == ST_BUSY);
    o_active = (state != ST_IDLE);
  end

  // Grant datapath: byte, id and pointer move only on a grant edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_data_tx   <= '0;
      o_req_ready <= '0;
      o_grant_id  <= '0;
      o_done      <= 1'b0;
      rr_ptr      <= '0;
    end else begin
      o_req_ready <= grant ? pick_oh : '0;
      o_done      <= (state == ST_BUSY) && !i_busy_tx;
      if (grant) begin
        o_data_tx  <= pick_byte;
        o_grant_id <= pick_idx;
        rr_ptr     <= (pick_idx == GW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [3:0]  i_req_valid = '0;
  logic [31:0] i_req_data = '0;
  logic [3:0]  o_req_ready;
  logic        o_str_tx;
  logic [7:0]  o_data_tx;
  logic        i_busy_tx;
  logic [1:0]  o_grant_id;
  logic        o_active;
  logic        o_done;
  logic        o_err;

  int n_checks = 0;
  int n_pass   = 0;
  int done_total = 0;

  // UART model controls
  bit comb_mode = 1'b0;
  bit never     = 1'b0;
  int busy_len  = 3;

  logic busy_q;
  logic served;
  int   bcnt;

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_str_tx    (o_str_tx),
    .o_data_tx   (o_data_tx),
    .i_busy_tx   (i_busy_tx),
    .o_grant_id  (o_grant_id),
    .o_active    (o_active),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  // UART model: delayed mode raises busy the cycle after start is seen and
  // holds it busy_len cycles; comb mode answers busy=start for one cycle.
  always @(posedge i_clk) begin
    if (!i_rst) begin
      busy_q <= 1'b0;
      served <= 1'b0;
      bcnt   <= 0;
    end else begin
      if (!o_str_tx) served <= 1'b0;
      if (busy_q) begin
        if (bcnt <= 1) begin
          busy_q <= 1'b0;
          served <= 1'b1;
        end
        bcnt <= bcnt - 1;
      end else if (o_str_tx && !served && !never) begin
        if (comb_mode) served <= 1'b1;
        else begin
          busy_q <= 1'b1;
          bcnt   <= busy_len;
        end
      end
    end
  end

  assign i_busy_tx = busy_q || (comb_mode && o_str_tx && !served && !never);

  always @(negedge i_clk) if (o_done) done_total++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_byte(input int k, input logic [7:0] b);
    i_req_data[8*k +: 8] = b;
  endtask

  task automatic do_reset();
    i_req_valid = '0;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst = 1'b1;
  endtask

  // Waits for a grant, checks it, follows the transfer to o_done.
  // gap = str-low cycles observed before this grant when called back to back.
  task automatic run_byte(input string tag, input int exp_id, input logic [7:0] exp_data,
                          input int exp_high, input bit drop, output int gap);
    int n, high, bad;
    n = 0;
    do begin
      @(negedge i_clk); #1;
      n++;
    end while (o_req_ready == '0 && n < 500);
    gap = n + 1;
    check({tag, "_ready"}, 32'(o_req_ready), 32'(1 << exp_id));
    check({tag, "_id"},    32'(o_grant_id),  32'(exp_id));
    check({tag, "_data"},  32'(o_data_tx),   32'(exp_data));
    check({tag, "_str"},   32'(o_str_tx),    1);
    if (drop) i_req_valid[exp_id] = 1'b0;
    high = 1; bad = 0; n = 0;
    while (!o_done && n < 500) begin
      @(negedge i_clk); #1;
      n++;
      if (o_str_tx) high++;
      if (o_str_tx && o_data_tx !== exp_data) bad++;
      if (o_req_ready != '0) bad++;
    end
    check({tag, "_done"},      32'(o_done),   1);
    check({tag, "_str_high"},  32'(high),     32'(exp_high));
    check({tag, "_stable"},    32'(bad),      0);
    check({tag, "_rel_str"},   32'(o_str_tx), 0);
    check({tag, "_rel_act"},   32'(o_active), 1);
    @(negedge i_clk); #1;
    check({tag, "_idle_act"},  32'(o_active), 0);
    check({tag, "_idle_done"}, 32'(o_done),   0);
  endtask

  initial begin
    int gap, n, high, d0;
    logic [7:0] b;

    // Reset state
    repeat (2) @(posedge i_clk);
    @(negedge i_clk); #1;
    check("rst_str",   32'(o_str_tx),    0);
    check("rst_data",  32'(o_data_tx),   0);
    check("rst_ready", 32'(o_req_ready), 0);
    check("rst_id",    32'(o_grant_id),  0);
    check("rst_act",   32'(o_active),    0);
    check("rst_done",  32'(o_done),      0);
    check("rst_err",   32'(o_err),       0);
    i_rst = 1'b1;

    // Single request, busy held 100 cycles: str high 1+1+100 cycles
    busy_len = 100;
    set_byte(0, 8'h41);
    i_req_valid = 4'b0001;
    d0 = done_total;
    run_byte("single", 0, 8'h41, 102, 1'b1, gap);
    check("single_done_cnt", 32'(done_total - d0), 1);

    // All valid: rotation 0,1,2,3,0 with a 2-cycle str-low gap
    do_reset();
    busy_len = 3;
    for (int k = 0; k < 4; k++) set_byte(k, 8'h10 + 8'(k));
    i_req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      b = 8'h10 + 8'(i % 4);
      run_byte("rot", i % 4, b, 5, 1'b0, gap);
      if (i > 0) check("rot_gap", 32'(gap), 2);
    end

    // Pointer wrap: after req2, pointer=3, req1 and req3 pending
    do_reset();
    set_byte(2, 8'h22);
    i_req_valid = 4'b0100;
    run_byte("wrap_a", 2, 8'h22, 5, 1'b1, gap);
    set_byte(1, 8'h21);
    set_byte(3, 8'h23);
    i_req_valid = 4'b1010;
    run_byte("wrap_b", 3, 8'h23, 5, 1'b1, gap);
    run_byte("wrap_c", 1, 8'h21, 5, 1'b1, gap);

    // Reset while in BUSY, req2 pending
    do_reset();
    busy_len = 20;
    set_byte(0, 8'hA5);
    i_req_valid = 4'b0001;
    n = 0;
    do begin
      @(negedge i_clk); #1;
      n++;
    end while (o_req_ready == '0 && n < 50);
    check("mid_ready", 32'(o_req_ready), 1);
    i_req_valid = 4'b0000;
    repeat (4) begin @(negedge i_clk); #1; end
    set_byte(2, 8'h62);
    i_req_valid = 4'b0100;
    check("mid_busy", 32'(o_str_tx & i_busy_tx), 1);
    d0 = done_total;
    i_rst = 1'b0;
    @(negedge i_clk); #1;
    check("mid_rst_str",  32'(o_str_tx),   0);
    check("mid_rst_act",  32'(o_active),   0);
    check("mid_rst_data", 32'(o_data_tx),  0);
    check("mid_rst_id",   32'(o_grant_id), 0);
    check("mid_rst_done", 32'(done_total - d0), 0);
    i_rst = 1'b1;
    run_byte("mid_after", 2, 8'h62, 22, 1'b1, gap);

    // Combinational busy: START->BUSY in one cycle, done one cycle later
    do_reset();
    comb_mode = 1'b1;
    set_byte(1, 8'h55);
    i_req_valid = 4'b0010;
    run_byte("comb", 1, 8'h55, 2, 1'b1, gap);
    comb_mode = 1'b0;

`ifdef UART_ARB_TIMEOUT_EN
    // Busy never rises: str dropped after 16 cycles, sticky err, no done
    do_reset();
    never = 1'b1;
    set_byte(3, 8'h77);
    i_req_valid = 4'b1000;
    n = 0;
    do begin
      @(negedge i_clk); #1;
      n++;
    end while (o_req_ready == '0 && n < 50);
    check("to_ready", 32'(o_req_ready), 32'h8);
    i_req_valid = 4'b0000;
    d0 = done_total;
    high = 1; n = 0;
    while (o_str_tx && n < 100) begin
      @(negedge i_clk); #1;
      n++;
      if (o_str_tx) high++;
    end
    check("to_str_high", 32'(high), 16);
    check("to_err",      32'(o_err), 1);
    check("to_act",      32'(o_active), 1);
    check("to_no_done",  32'(done_total - d0), 0);
    never = 1'b0;
    busy_len = 3;
    set_byte(0, 8'h88);
    i_req_valid = 4'b0001;
    run_byte("to_next", 0, 8'h88, 5, 1'b1, gap);
    check("to_err_sticky", 32'(o_err), 1);
`else
    check("err_tied", 32'(o_err), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
